acc_sequencer: RTL
==================

ACC_SEQUENCER -- requirements
Module: acc_sequencer

Interface
REQ-001 The block SHALL have input clk, 1 bit, the rising-edge clock for all state.
REQ-002 The block SHALL have input reset, 1 bit, asynchronous, active-high.
REQ-003 The block SHALL have input start, 1 bit, a single-cycle pulse that starts program execution.
REQ-004 The block SHALL have output imem_addr, 8 bits, the instruction memory address (program counter).
REQ-005 The block SHALL have output imem_rd_en, 1 bit, the instruction memory read strobe.
REQ-006 The block SHALL have input imem_rdata, 36 bits, the instruction word ([35:32] opcode, [31:0] operand), valid one cycle after imem_rd_en.
REQ-007 The block SHALL have output ac_opcode, 4 bits, the opcode driven to the accumulator.
REQ-008 The block SHALL have output ac_operand, 32 bits, the operand driven to the accumulator.
REQ-009 The block SHALL have input ac_out, 32 bits, the current accumulator value.
REQ-010 The block SHALL have output busy, 1 bit, high from start acceptance until halt.
REQ-011 The block SHALL have output done, 1 bit, high while halted after a HALT instruction.

Function
REQ-012 The block SHALL use the opcodes ADD=4'h0, LOAD=4'h2, JMP=4'h8, JZ=4'h9, HALT=4'hE and NO_OP=4'hF; every other value SHALL execute as NO_OP.
REQ-013 The FSM SHALL have the states IDLE, FETCH, DECODE, EXEC and DONE.
REQ-014 In IDLE or DONE, a start pulse SHALL clear the PC to 0 and move to FETCH; start SHALL be ignored in any other state.
REQ-015 In FETCH, imem_rd_en=1 and imem_addr=PC for exactly one cycle, after which the FSM SHALL move to DECODE.
REQ-016 In DECODE, imem_rdata SHALL be latched into an instruction register, after which the FSM SHALL move to EXEC.
REQ-017 In EXEC, ADD or LOAD SHALL drive ac_opcode and ac_operand from the instruction register for exactly one cycle, then PC+1 and go to FETCH.
REQ-018 In EXEC, JMP SHALL set PC to operand[7:0] and go to FETCH, with ac_opcode=NO_OP.
REQ-019 In EXEC, JZ SHALL set PC to operand[7:0] if ac_out==0 and to PC+1 otherwise, then go to FETCH.
REQ-020 In EXEC, HALT SHALL go to DONE with the PC unchanged; NO_OP SHALL set PC+1 and go to FETCH.
REQ-021 Each instruction SHALL take exactly 3 cycles; JZ SHALL sample ac_out in EXEC, which reflects all prior instructions.
REQ-022 ac_opcode SHALL be NO_OP and ac_operand SHALL be 0 in every cycle other than an EXEC of ADD or LOAD; all outputs SHALL be registered.
REQ-023 PC+1 SHALL wrap from 8'hFF to 8'h00 without error.
REQ-024 busy SHALL be 1 in FETCH, DECODE and EXEC; done SHALL be 1 only in DONE.

Reset
REQ-025 Reset SHALL force IDLE, PC=0, imem_rd_en=0, ac_opcode=4'hF, ac_operand=0, busy=0 and done=0, at any time including mid-instruction.
REQ-026 After reset, the block SHALL issue no accumulator operation until a new start pulse arrives.

Configuration
REQ-027 With ACC_SEQ_BRANCH_EN defined, JMP and JZ SHALL behave as in REQ-018 and REQ-019.
REQ-028 Without ACC_SEQ_BRANCH_EN, opcodes 4'h8 and 4'h9 SHALL execute as NO_OP (PC+1), and ac_out SHALL be unused.

Structure
REQ-029 The package acc_seq_pkg SHALL hold the opcode constants, the FSM state enum, and the PC and instruction width parameters.
REQ-030 The block SHALL be a single module with no sub-modules; it SHALL instantiate neither the accumulator nor the memory.

Verification
REQ-031 Program {LOAD 5, ADD 7, HALT} followed by start: the accumulator SHALL read 12, done SHALL rise 9 cycles after the FETCH at PC 0, and busy SHALL fall.
REQ-032 The bench SHALL check that ac_opcode is 4'hF in every FETCH and DECODE cycle and that ADD/LOAD each appear for exactly one cycle.
REQ-033 With BRANCH_EN, program {LOAD 0, JZ 4, ADD 1, HALT, ADD 9, HALT}: the result SHALL be 9 and done SHALL be set with PC=5.
REQ-034 Without BRANCH_EN, the REQ-033 program SHALL end with 1 and done SHALL be set with PC=3.
REQ-035 Reset asserted in EXEC of ADD 3 SHALL apply no add, force IDLE, and ignore a later stale imem_rdata.
REQ-036 PC=8'hFF holding ADD 1 and address 0 holding HALT SHALL wrap the PC to 0, and a start pulse while busy SHALL be ignored.

Source files
------------

// File: rtl/acc_seq_pkg.sv
// Shared definitions for the accumulator sequencer: opcodes, FSM states and widths.
package acc_seq_pkg;

    localparam int PC_W    = 8;
    localparam int OPC_W   = 4;
    localparam int OPR_W   = 32;
    localparam int INSTR_W = OPC_W + OPR_W;

    localparam logic [OPC_W-1:0] OP_ADD  = 4'h0;
    localparam logic [OPC_W-1:0] OP_LOAD = 4'h2;
    localparam logic [OPC_W-1:0] OP_JMP  = 4'h8;
    localparam logic [OPC_W-1:0] OP_JZ   = 4'h9;
    localparam logic [OPC_W-1:0] OP_HALT = 4'hE;
    localparam logic [OPC_W-1:0] OP_NOP  = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_DONE
    } state_t;

    // True for the opcodes that are forwarded to the accumulator.
    function automatic logic is_ac_op(input logic [OPC_W-1:0] op);
        return (op == OP_ADD) || (op == OP_LOAD);
    endfunction

endpackage

// File: rtl/acc_seq_if.sv
// Instruction-memory and accumulator bus between the sequencer (master) and its
// surroundings (slave).
interface acc_seq_if;
    import acc_seq_pkg::*;

    logic [PC_W-1:0]    imem_addr;
    logic               imem_rd_en;
    logic [INSTR_W-1:0] imem_rdata;
    logic [OPC_W-1:0]   ac_opcode;
    logic [OPR_W-1:0]   ac_operand;
    logic [OPR_W-1:0]   ac_out;

    modport master (
        output imem_addr,
        output imem_rd_en,
        output ac_opcode,
        output ac_operand,
        input  imem_rdata,
        input  ac_out
    );

    modport slave (
        input  imem_addr,
        input  imem_rd_en,
        input  ac_opcode,
        input  ac_operand,
        output imem_rdata,
        output ac_out
    );

endinterface

// File: rtl/acc_sequencer.sv
// Accumulator program sequencer: fetches 36-bit instructions from an external
// memory and issues ADD/LOAD operations to an external accumulator, three
// cycles per instruction.
// Build option: define ACC_SEQ_BRANCH_EN to enable JMP/JZ; without it both
// branch opcodes execute as NO_OP and ac_out is not looked at.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// FETCH  | read strobe issued at address PC
// DECODE | memory word arrives and is captured into the instruction register
// EXEC   | ADD/LOAD presented to the accumulator, next PC chosen
// DONE   | halted after HALT, waiting for a new start
module acc_sequencer
    import acc_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    acc_seq_if.master  bus,
    output logic       busy,
    output logic       done
);

    state_t             state_q;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    pc_d;
    logic [OPC_W-1:0]   ir_op_q;
    logic               rd_en_q;
    logic [OPC_W-1:0]   ac_op_q;
    logic [OPR_W-1:0]   ac_opr_q;
    logic               busy_q;
    logic               done_q;
`ifdef ACC_SEQ_BRANCH_EN
    logic [PC_W-1:0]    ir_tgt_q;
`endif

    // Next PC at the end of EXEC; the increment wraps naturally at 8 bits.
    always_comb begin
        pc_d = pc_q + 8'd1;
`ifdef ACC_SEQ_BRANCH_EN
        if (ir_op_q == OP_JMP) begin
            pc_d = ir_tgt_q;
        end else if ((ir_op_q == OP_JZ) && (bus.ac_out == '0)) begin
            pc_d = ir_tgt_q;
        end
`endif
    end

    // Sequencer FSM; every output is a register loaded on the edge entering its state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            ir_op_q  <= OP_NOP;
            rd_en_q  <= 1'b0;
            ac_op_q  <= OP_NOP;
            ac_opr_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef ACC_SEQ_BRANCH_EN
            ir_tgt_q <= '0;
`endif
        end else begin
            rd_en_q  <= 1'b0;
            ac_op_q  <= OP_NOP;
            ac_opr_q <= '0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        pc_q    <= '0;
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    ir_op_q <= bus.imem_rdata[INSTR_W-1:OPR_W];
`ifdef ACC_SEQ_BRANCH_EN
                    ir_tgt_q <= bus.imem_rdata[PC_W-1:0];
`endif
                    // The accumulator op is staged here so it is a clean register in EXEC.
                    if (is_ac_op(bus.imem_rdata[INSTR_W-1:OPR_W])) begin
                        ac_op_q  <= bus.imem_rdata[INSTR_W-1:OPR_W];
                        ac_opr_q <= bus.imem_rdata[OPR_W-1:0];
                    end
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    if (ir_op_q == OP_HALT) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        pc_q    <= pc_d;
                        rd_en_q <= 1'b1;
                        state_q <= S_FETCH;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.imem_addr  = pc_q;
    assign bus.imem_rd_en = rd_en_q;
    assign bus.ac_opcode  = ac_op_q;
    assign bus.ac_operand = ac_opr_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule
